block_sched: RTL

- Image-level scheduler sharing NUM_CORES compress_block cores across every 8x8 block of an image.
- Hands out block coordinates in raster order to idle cores, one dispatch per cycle.
- Collects finished cores through a single round-robin-arbitrated result port with valid/ready, which the coefficient store uses to place results.
- Replaces lock-step row processing with per-core independent scheduling.

---
 rtl/compressor_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 72 +++++++
 rtl/block_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/compressor_pkg.sv
// Shared scheduler types: FSM state encoding, block-coordinate struct and
// helpers deriving the block grid from image dimensions.
package compressor_pkg;

  localparam int unsigned BlkRowWidth = 6;
  localparam int unsigned BlkColWidth = 7;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sched_state_t;

  typedef struct packed {
    logic [BlkRowWidth-1:0] row;
    logic [BlkColWidth-1:0] col;
  } blk_coord_t;

  function automatic int unsigned num_blocks_in_row(int unsigned img_cols,
                                                    int unsigned log2_bs);
    return img_cols >> log2_bs;
  endfunction

  function automatic int unsigned num_blocks_in_col(int unsigned img_rows,
                                                    int unsigned log2_bs);
    return img_rows >> log2_bs;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, which moves past the
// granted requester on advance; an unaccepted grant is held until accepted.
module rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_i,
  input  logic                advance_i,
  output logic [N-1:0]        gnt_o,
  output logic [IdxWidth-1:0] gnt_idx_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] gnt_idx;
  logic [IdxWidth-1:0] cand;
  logic                found;

  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    // A stalled grant stays put even if a requester closer to the pointer appears.
    if (lock_q && req_i[lock_idx_q]) begin
      gnt_idx = lock_idx_q;
      found   = 1'b1;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        cand = IdxWidth'((32'(ptr_q) + i) % N);
        if (!found && req_i[cand]) begin
          gnt_idx = cand;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found) gnt_o[gnt_idx] = 1'b1;
  end

  assign gnt_idx_o = gnt_idx;

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    if (found && advance_i) begin
      ptr_d = (gnt_idx == IdxWidth'(N - 1)) ? '0 : gnt_idx + IdxWidth'(1);
    end else if (found) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/block_sched.sv
// Image-level scheduler: dispatches 8x8 blocks in raster order to idle cores and
// funnels finished results through one arbitrated port. BLOCK_SCHED_PERF_EN adds counters.
module block_sched
  import compressor_pkg::*;
#(
  parameter int unsigned IMG_ROWS        = 480,
  parameter int unsigned IMG_COLS        = 640,
  parameter int unsigned LOG2_BLOCK_SIZE = 3,
  parameter int unsigned NUM_CORES       = 4,
  parameter int unsigned CORE_IDX_WIDTH  = 2,
  parameter int unsigned BLK_ROW_WIDTH   = 6,
  parameter int unsigned BLK_COL_WIDTH   = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_img,
  output logic                      img_done,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [BLK_ROW_WIDTH-1:0]  disp_blk_row,
  output logic [BLK_COL_WIDTH-1:0]  disp_blk_col,
  input  logic [NUM_CORES-1:0]      core_done,
  output logic [NUM_CORES-1:0]      core_ack,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [CORE_IDX_WIDTH-1:0] wr_core,
  output logic [BLK_ROW_WIDTH-1:0]  wr_blk_row,
  output logic [BLK_COL_WIDTH-1:0]  wr_blk_col,
  output logic                      sched_busy
`ifdef BLOCK_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_cycles,
  output logic [31:0]               perf_wr_stalls
`endif
);

  localparam int unsigned NumBlkRow = num_blocks_in_row(IMG_COLS, LOG2_BLOCK_SIZE);
  localparam int unsigned NumBlkCol = num_blocks_in_col(IMG_ROWS, LOG2_BLOCK_SIZE);
  localparam logic [BlkColWidth-1:0] LastCol = BlkColWidth'(NumBlkRow - 1);
  localparam logic [BlkRowWidth-1:0] LastRow = BlkRowWidth'(NumBlkCol - 1);

  sched_state_t              state_q, state_d;
  logic [NUM_CORES-1:0]      busy_q, busy_d;
  blk_coord_t                cnt_q, cnt_d;
  blk_coord_t                tag_q [NUM_CORES];

  logic [CORE_IDX_WIDTH-1:0] disp_idx;
  logic                      disp_avail;
  logic                      disp_fire;
  logic                      last_disp;
  logic                      start_acc;
  logic [NUM_CORES-1:0]      elig;
  logic [NUM_CORES-1:0]      gnt;
  logic [CORE_IDX_WIDTH-1:0] gnt_idx;
  logic                      wr_xfer;

  assign start_acc = (state_q == StIdle) && start_img;

  // Lowest-index idle core wins dispatch.
  always_comb begin
    disp_idx   = '0;
    disp_avail = 1'b0;
    for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
      if (!busy_q[k]) begin
        disp_idx   = CORE_IDX_WIDTH'(k);
        disp_avail = 1'b1;
      end
    end
  end

  assign disp_fire = (state_q == StRun) && disp_avail;
  assign last_disp = disp_fire && (cnt_q.row == LastRow) && (cnt_q.col == LastCol);

  always_comb begin
    core_start = '0;
    if (disp_fire) core_start[disp_idx] = 1'b1;
  end

  assign disp_blk_row = BLK_ROW_WIDTH'(cnt_q.row);
  assign disp_blk_col = BLK_COL_WIDTH'(cnt_q.col);

  always_comb begin
    cnt_d = cnt_q;
    if (start_acc) begin
      cnt_d = '0;
    end else if (disp_fire) begin
      if (cnt_q.col == LastCol) begin
        cnt_d.col = '0;
        cnt_d.row = (cnt_q.row == LastRow) ? '0 : cnt_q.row + BlkRowWidth'(1);
      end else begin
        cnt_d.col = cnt_q.col + BlkColWidth'(1);
      end
    end
  end

  // Results from cores we never dispatched to are ignored.
  assign elig = core_done & busy_q;

  rr_arbiter #(
    .N        (NUM_CORES),
    .IdxWidth (CORE_IDX_WIDTH)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req_i     (elig),
    .advance_i (wr_ready),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign wr_valid   = |elig;
  assign wr_xfer    = wr_valid && wr_ready;
  assign core_ack   = wr_xfer ? gnt : '0;
  assign wr_core    = gnt_idx;
  assign wr_blk_row = BLK_ROW_WIDTH'(tag_q[gnt_idx].row);
  assign wr_blk_col = BLK_COL_WIDTH'(tag_q[gnt_idx].col);

  assign busy_d = (busy_q | core_start) & ~core_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_img) state_d = StRun;
      StRun:   if (last_disp) state_d = StDrain;
      StDrain: if (busy_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign img_done   = (state_q == StDone);
  assign sched_busy = (state_q == StRun) || (state_q == StDrain);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_CORES); k++) tag_q[k] <= '0;
    end else if (disp_fire) begin
      tag_q[disp_idx] <= cnt_q;
    end
  end

`ifdef BLOCK_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_wr_stalls_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      perf_cycles_q    <= '0;
      perf_wr_stalls_q <= '0;
    end else begin
      if (sched_busy && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (wr_valid && !wr_ready && (perf_wr_stalls_q != '1)) begin
        perf_wr_stalls_q <= perf_wr_stalls_q + 32'd1;
      end
    end
  end

  assign perf_cycles    = perf_cycles_q;
  assign perf_wr_stalls = perf_wr_stalls_q;
`endif

endmodule
